// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-visible register front end.
// Holds the register index map, STATUS and CTRL bit positions and the
// video-port state encoding used by ppu_cpu_regs and ppu_vram_port.
package ppu_pkg;

    // CPU register indices
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_OAMADDR = 3'd3;
    localparam logic [2:0] REG_OAMDATA = 3'd4;
    localparam logic [2:0] REG_SCROLL  = 3'd5;
    localparam logic [2:0] REG_ADDR    = 3'd6;
    localparam logic [2:0] REG_DATA    = 3'd7;

    // STATUS bit positions
    localparam int STAT_VBL = 7;
    localparam int STAT_S0  = 6;
    localparam int STAT_OVF = 5;

    // CTRL bit positions
    localparam int CTRL_NMI_EN = 7;
    localparam int CTRL_INC    = 2;
    localparam int CTRL_NT_HI  = 1;
    localparam int CTRL_NT_LO  = 0;

    // Video-port sequencer states
    typedef enum logic [1:0] {
        VP_IDLE = 2'd0,
        VP_RD   = 2'd1,
        VP_WR   = 2'd2
    } vport_state_t;

endpackage

// File: rtl/ppu_vram_port.sv
// Deferred video-bus sequencer for PPUDATA accesses.
// A DATA access accepted on a strobe edge becomes a one-cycle RD or WR
// bus cycle immediately after it; inc requests the v increment at the
// end of that bus cycle and rd_done tells the register file to capture
// the read buffer at the same edge.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req, req_rd    DATA access seen this cycle, and whether it is a read
//   req_data       CPU write data for a DATA write
//   v_rd_n, v_we_n registered video bus strobes
//   v_wdata        registered video write data
//   rd_done, inc   bus cycle in progress (read / any)
module ppu_vram_port
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       req_rd,
    input  logic [7:0] req_data,
    output logic       v_rd_n,
    output logic       v_we_n,
    output logic [7:0] v_wdata,
    output logic       rd_done,
    output logic       inc
);

    vport_state_t state_reg;

    // Every bus cycle lasts exactly one clock, so a DATA access arriving
    // while a bus cycle is in flight is the one-deep backlog: it is
    // issued at the edge that retires the current cycle and therefore
    // follows immediately, addressing the already-incremented v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= VP_IDLE;
            v_rd_n    <= 1'b1;
            v_we_n    <= 1'b1;
            v_wdata   <= 8'h00;
        end else begin
            if (req) begin
                state_reg <= req_rd ? VP_RD : VP_WR;
            end else begin
                state_reg <= VP_IDLE;
            end
            v_rd_n <= ~(req & req_rd);
            v_we_n <= ~(req & ~req_rd);
            if (req && !req_rd) begin
                v_wdata <= req_data;
            end
        end
    end

    assign rd_done = (state_reg == VP_RD);
    assign inc     = (state_reg != VP_IDLE);

endmodule

// File: rtl/ppu_cpu_regs.sv
// CPU-visible 2C02 register file: CTRL, MASK, STATUS, OAMADDR, OAMDATA,
// SCROLL, ADDR, DATA with loopy t/v, write toggle, PPUDATA read buffer,
// vblank/sprite flags, registered ~NMI and a sequenced video bus port.
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_cs_n, i_rs, i_rw, i_data  CPU register access (one-cycle strobe)
//   o_data                      CPU read data (combinational)
//   o_int_n                     ~NMI
//   i_vblank_*, i_sprite*       flag set/clear pulses from the timing core
//   o_v_*, i_v_data             video bus
//   o_oam_*, i_oam_data         OAM port
//   o_ctrl, o_mask, o_v, o_t, o_fine_x  state for the renderer
// The t/v bit layout is the 15-bit loopy layout (fine-Y in [14:12],
// nametable in [11:10], coarse Y in [9:5], coarse X in [4:0]).
module ppu_cpu_regs
    import ppu_pkg::*;
#(
    parameter int VADDR_W    = 14,
    parameter int OAM_ADDR_W = 8,
    parameter int INC_DOWN   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_cs_n,
    input  logic [2:0]            i_rs,
    input  logic                  i_rw,
    input  logic [7:0]            i_data,
    output logic [7:0]            o_data,
    output logic                  o_int_n,
    input  logic                  i_vblank_set,
    input  logic                  i_vblank_clear,
    input  logic                  i_sprite0_hit,
    input  logic                  i_sprite_ovf,
    output logic                  o_v_rd_n,
    output logic                  o_v_we_n,
    output logic [VADDR_W-1:0]    o_v_address,
    output logic [7:0]            o_v_data,
    input  logic [7:0]            i_v_data,
    output logic [OAM_ADDR_W-1:0] o_oam_addr,
    output logic                  o_oam_we,
    output logic [7:0]            o_oam_data,
    input  logic [7:0]            i_oam_data,
    output logic [7:0]            o_ctrl,
    output logic [7:0]            o_mask,
    output logic [VADDR_W:0]      o_v,
    output logic [VADDR_W:0]      o_t,
    output logic [2:0]            o_fine_x
);

    localparam int LW = VADDR_W + 1;

    logic                  cpu_wr, cpu_rd;
    logic [7:0]            ctrl_reg, ctrl_next, mask_reg, mask_next;
    logic [OAM_ADDR_W-1:0] oamaddr_reg, oamaddr_next;
    logic [LW-1:0]         t_reg, t_next, v_reg, v_next, inc_amt;
    logic [2:0]            fine_x_reg, fine_x_next;
    logic                  w_reg, w_next;
    logic [7:0]            buffer_reg, buffer_next, bus_reg, bus_next;
    logic                  vbl_reg, vbl_next, s0_reg, s0_next, ovf_reg, ovf_next;
    logic                  int_n_reg;
    logic                  v_load;
    logic                  port_rd_done, port_inc;
    logic [7:0]            status_byte;

    assign cpu_wr = ~i_cs_n & ~i_rw;
    assign cpu_rd = ~i_cs_n & i_rw;

    assign inc_amt = ctrl_reg[CTRL_INC] ? LW'(INC_DOWN) : LW'(1);

    ppu_vram_port u_port (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .req      (~i_cs_n & (i_rs == REG_DATA)),
        .req_rd   (i_rw),
        .req_data (i_data),
        .v_rd_n   (o_v_rd_n),
        .v_we_n   (o_v_we_n),
        .v_wdata  (o_v_data),
        .rd_done  (port_rd_done),
        .inc      (port_inc)
    );

    always_comb begin
        ctrl_next    = ctrl_reg;
        mask_next    = mask_reg;
        oamaddr_next = oamaddr_reg;
        t_next       = t_reg;
        v_next       = v_reg;
        fine_x_next  = fine_x_reg;
        w_next       = w_reg;
        buffer_next  = buffer_reg;
        bus_next     = bus_reg;
        vbl_next     = vbl_reg;
        s0_next      = s0_reg;
        ovf_next     = ovf_reg;
        v_load       = 1'b0;

        if (cpu_wr) begin
            bus_next = i_data;
            case (i_rs)
                REG_CTRL: begin
                    ctrl_next      = i_data;
                    t_next[11:10]  = i_data[CTRL_NT_HI:CTRL_NT_LO];
                end
                REG_MASK:    mask_next    = i_data;
                REG_OAMADDR: oamaddr_next = OAM_ADDR_W'(i_data);
                REG_OAMDATA: oamaddr_next = oamaddr_reg + 1'b1;
                REG_SCROLL: begin
                    w_next = ~w_reg;
                    if (!w_reg) begin
                        t_next[4:0] = i_data[7:3];
                        fine_x_next = i_data[2:0];
                    end else begin
                        t_next[14:12] = i_data[2:0];
                        t_next[9:5]   = i_data[7:3];
                    end
                end
                REG_ADDR: begin
                    w_next = ~w_reg;
                    if (!w_reg) begin
                        t_next[13:8] = i_data[5:0];
                        t_next[14]   = 1'b0;
                    end else begin
                        t_next[7:0] = i_data;
                        v_load      = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (cpu_rd && i_rs == REG_STATUS) begin
            vbl_next = 1'b0;
            w_next   = 1'b0;
        end

        // Set pulses are applied last so they win over any clear.
        if (i_vblank_clear) begin
            vbl_next = 1'b0;
            s0_next  = 1'b0;
            ovf_next = 1'b0;
        end
        if (i_vblank_set)  vbl_next = 1'b1;
        if (i_sprite0_hit) s0_next  = 1'b1;
        if (i_sprite_ovf)  ovf_next = 1'b1;

        if (port_rd_done) buffer_next = i_v_data;

        // A CPU load of v takes precedence over a same-edge increment.
        if (v_load) begin
            v_next = t_next;
        end else if (port_inc) begin
            v_next = v_reg + inc_amt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctrl_reg    <= 8'h00;
            mask_reg    <= 8'h00;
            oamaddr_reg <= '0;
            t_reg       <= '0;
            v_reg       <= '0;
            fine_x_reg  <= 3'd0;
            w_reg       <= 1'b0;
            buffer_reg  <= 8'h00;
            bus_reg     <= 8'h00;
            vbl_reg     <= 1'b0;
            s0_reg      <= 1'b0;
            ovf_reg     <= 1'b0;
            int_n_reg   <= 1'b1;
        end else begin
            ctrl_reg    <= ctrl_next;
            mask_reg    <= mask_next;
            oamaddr_reg <= oamaddr_next;
            t_reg       <= t_next;
            v_reg       <= v_next;
            fine_x_reg  <= fine_x_next;
            w_reg       <= w_next;
            buffer_reg  <= buffer_next;
            bus_reg     <= bus_next;
            vbl_reg     <= vbl_next;
            s0_reg      <= s0_next;
            ovf_reg     <= ovf_next;
            // Computed from next-state so NMI follows the edge that caused it.
            int_n_reg   <= ~(vbl_next & ctrl_next[CTRL_NMI_EN]);
        end
    end

    always_comb begin
        status_byte           = 8'h00;
        status_byte[STAT_VBL] = vbl_reg;
        status_byte[STAT_S0]  = s0_reg;
        status_byte[STAT_OVF] = ovf_reg;
    end

    always_comb begin
        o_data = 8'h00;
        if (cpu_rd) begin
            case (i_rs)
                REG_STATUS:  o_data = status_byte;
                REG_OAMDATA: o_data = i_oam_data;
                REG_DATA:    o_data = buffer_reg;
                default:     o_data = bus_reg;
            endcase
        end
    end

    assign o_int_n     = int_n_reg;
    assign o_v_address = v_reg[VADDR_W-1:0];
    assign o_oam_addr  = oamaddr_reg;
    assign o_oam_we    = cpu_wr & (i_rs == REG_OAMDATA);
    assign o_oam_data  = i_data;
    assign o_ctrl      = ctrl_reg;
    assign o_mask      = mask_reg;
    assign o_v         = v_reg;
    assign o_t         = t_reg;
    assign o_fine_x    = fine_x_reg;

endmodule

// File: tb/tb_ppu_cpu_regs.sv
module tb_ppu_cpu_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic [2:0]  rs = 3'd0;
    logic        rw = 1'b1;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        int_n;
    logic        vblank_set = 1'b0, vblank_clear = 1'b0;
    logic        sprite0_hit = 1'b0, sprite_ovf = 1'b0;
    logic        v_rd_n, v_we_n;
    logic [13:0] v_address;
    logic [7:0]  v_wdata, v_rdata;
    logic [7:0]  oam_addr, oam_wdata, oam_rdata;
    logic        oam_we;
    logic [7:0]  ctrl, mask;
    logic [14:0] v, t;
    logic [2:0]  fine_x;

    int n_checks = 0;
    int n_errors = 0;

    logic [21:0] exp_vwr[$];   // {address, data}
    logic [13:0] exp_vrd[$];
    logic [15:0] exp_oam[$];   // {address, data}
    logic [7:0]  exp_cpu[$];

    logic [7:0] vmem [0:16383];

    always #5 clk = ~clk;

    ppu_cpu_regs #(.VADDR_W(14), .OAM_ADDR_W(8), .INC_DOWN(32)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_cs_n         (cs_n),
        .i_rs           (rs),
        .i_rw           (rw),
        .i_data         (wdata),
        .o_data         (rdata),
        .o_int_n        (int_n),
        .i_vblank_set   (vblank_set),
        .i_vblank_clear (vblank_clear),
        .i_sprite0_hit  (sprite0_hit),
        .i_sprite_ovf   (sprite_ovf),
        .o_v_rd_n       (v_rd_n),
        .o_v_we_n       (v_we_n),
        .o_v_address    (v_address),
        .o_v_data       (v_wdata),
        .i_v_data       (v_rdata),
        .o_oam_addr     (oam_addr),
        .o_oam_we       (oam_we),
        .o_oam_data     (oam_wdata),
        .i_oam_data     (oam_rdata),
        .o_ctrl         (ctrl),
        .o_mask         (mask),
        .o_v            (v),
        .o_t            (t),
        .o_fine_x       (fine_x)
    );

    // Video memory and OAM models
    assign v_rdata   = vmem[v_address];
    assign oam_rdata = oam_addr ^ 8'h5A;

    always @(posedge clk) begin
        if (!v_we_n) vmem[v_address] <= v_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    // Monitor: compares every DUT-presented transaction against the queues.
    always @(negedge clk) begin
        if (!v_we_n) begin
            if (exp_vwr.size() == 0) unexpected("vram_write");
            else begin
                logic [21:0] e;
                e = exp_vwr.pop_front();
                check("vwr_addr", 32'(v_address), 32'(e[21:8]));
                check("vwr_data", 32'(v_wdata), 32'(e[7:0]));
                $display("vram write addr=0x%04h data=0x%02h", v_address, v_wdata);
            end
        end
        if (!v_rd_n) begin
            if (exp_vrd.size() == 0) unexpected("vram_read");
            else begin
                logic [13:0] a;
                a = exp_vrd.pop_front();
                check("vrd_addr", 32'(v_address), 32'(a));
                $display("vram read  addr=0x%04h data=0x%02h", v_address, v_rdata);
            end
        end
        if (oam_we) begin
            if (exp_oam.size() == 0) unexpected("oam_write");
            else begin
                logic [15:0] o;
                o = exp_oam.pop_front();
                check("oam_addr", 32'(oam_addr), 32'(o[15:8]));
                check("oam_data", 32'(oam_wdata), 32'(o[7:0]));
                $display("oam write  addr=0x%02h data=0x%02h", oam_addr, oam_wdata);
            end
        end
        if (!cs_n && rw) begin
            if (exp_cpu.size() == 0) unexpected("cpu_read");
            else begin
                logic [7:0] d;
                d = exp_cpu.pop_front();
                check("cpu_rdata", 32'(rdata), 32'(d));
                $display("cpu read   rs=%0d data=0x%02h", rs, rdata);
            end
        end
    end

    // One CPU access followed by one idle cycle for the video port.
    task automatic cpu_access(input logic r, input logic [2:0] sel, input logic [7:0] d,
                              input logic with_vset);
        @(posedge clk); #1;
        cs_n = 1'b0; rw = r; rs = sel; wdata = d; vblank_set = with_vset;
        @(posedge clk); #1;
        cs_n = 1'b1; rw = 1'b1; vblank_set = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cpu_wr(input logic [2:0] sel, input logic [7:0] d);
        cpu_access(1'b0, sel, d, 1'b0);
    endtask

    task automatic cpu_rd(input logic [2:0] sel, input logic [7:0] exp);
        exp_cpu.push_back(exp);
        cpu_access(1'b1, sel, 8'h00, 1'b0);
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        case (which)
            0: vblank_set = 1'b1;
            1: vblank_clear = 1'b1;
            default: begin sprite0_hit = 1'b1; sprite_ovf = 1'b1; end
        endcase
        @(posedge clk); #1;
        vblank_set = 1'b0; vblank_clear = 1'b0; sprite0_hit = 1'b0; sprite_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
        vmem[14'h2000] = 8'hAA;
        vmem[14'h2001] = 8'hBB;

        repeat (3) @(posedge clk);
        #1;
        check("rst_int_n", 32'(int_n), 32'h1);
        check("rst_rd_n", 32'(v_rd_n), 32'h1);
        check("rst_we_n", 32'(v_we_n), 32'h1);
        check("rst_ctrl", 32'(ctrl), 32'h0);
        check("rst_v", 32'(v), 32'h0);
        check("rst_odata", 32'(rdata), 32'h0);
        rst_n = 1'b1;

        // ADDR / DATA writes with both increment modes
        cpu_wr(3'd6, 8'h21);
        cpu_wr(3'd6, 8'h08);
        check("addr_v", 32'(v), 32'h2108);
        exp_vwr.push_back({14'h2108, 8'h55});
        cpu_wr(3'd7, 8'h55);
        check("inc1_v", 32'(v), 32'h2109);
        cpu_wr(3'd0, 8'h04);
        check("ctrl_inc", 32'(ctrl), 32'h04);
        exp_vwr.push_back({14'h2109, 8'h77});
        cpu_wr(3'd7, 8'h77);
        check("inc32_v", 32'(v), 32'h2129);
        cpu_wr(3'd0, 8'h00);

        // Back-to-back DATA writes: second one queued behind the first
        exp_vwr.push_back({14'h2129, 8'h01});
        exp_vwr.push_back({14'h212A, 8'h02});
        @(posedge clk); #1;
        cs_n = 1'b0; rw = 1'b0; rs = 3'd7; wdata = 8'h01;
        @(posedge clk); #1;
        wdata = 8'h02;
        @(posedge clk); #1;
        cs_n = 1'b1; rw = 1'b1;
        @(posedge clk); #1;
        check("b2b_v", 32'(v), 32'h212B);

        // Buffered DATA reads
        cpu_wr(3'd6, 8'h20);
        cpu_wr(3'd6, 8'h00);
        exp_vrd.push_back(14'h2000);
        cpu_rd(3'd7, 8'h00);
        exp_vrd.push_back(14'h2001);
        cpu_rd(3'd7, 8'hAA);
        exp_vrd.push_back(14'h2002);
        cpu_rd(3'd7, 8'hBB);
        check("rd_v", 32'(v), 32'h2003);

        // Open-bus reads of write-only registers
        cpu_wr(3'd1, 8'h1E);
        check("mask", 32'(mask), 32'h1E);
        cpu_rd(3'd0, 8'h1E);
        cpu_rd(3'd5, 8'h1E);

        // Vblank / NMI
        cpu_wr(3'd0, 8'h80);
        check("nmi_idle", 32'(int_n), 32'h1);
        pulse(0);
        check("nmi_assert", 32'(int_n), 32'h0);
        cpu_rd(3'd2, 8'h80);
        check("nmi_release", 32'(int_n), 32'h1);
        cpu_rd(3'd2, 8'h00);

        // Set beats a same-cycle STATUS-read clear; read shows pre-edge value
        exp_cpu.push_back(8'h00);
        cpu_access(1'b1, 3'd2, 8'h00, 1'b1);
        check("setwins_nmi", 32'(int_n), 32'h0);
        cpu_rd(3'd2, 8'h80);

        // Enabling NMI while vblank is already set
        cpu_wr(3'd0, 8'h00);
        pulse(0);
        check("nmi_masked", 32'(int_n), 32'h1);
        cpu_wr(3'd0, 8'h80);
        check("nmi_late_en", 32'(int_n), 32'h0);
        cpu_rd(3'd2, 8'h80);

        // Sprite flags: survive STATUS reads, cleared by vblank_clear
        pulse(2);
        cpu_rd(3'd2, 8'h60);
        cpu_rd(3'd2, 8'h60);
        pulse(1);
        cpu_rd(3'd2, 8'h00);

        // SCROLL writes
        cpu_wr(3'd5, 8'h7D);
        cpu_wr(3'd5, 8'h5E);
        check("fine_x", 32'(fine_x), 32'h5);
        check("t_cx", 32'(t[4:0]), 32'h0F);
        check("t_cy", 32'(t[9:5]), 32'h0B);
        check("t_fy", 32'(t[14:12]), 32'h6);
        cpu_wr(3'd5, 8'h7D);
        cpu_rd(3'd2, 8'h00);
        cpu_wr(3'd5, 8'h5E);
        check("w_reset_cx", 32'(t[4:0]), 32'h0B);
        check("w_reset_fx", 32'(fine_x), 32'h6);
        check("w_reset_fy", 32'(t[14:12]), 32'h6);

        // OAM write with wrap, then OAM read without increment
        cpu_wr(3'd3, 8'hFF);
        exp_oam.push_back({8'hFF, 8'h12});
        cpu_wr(3'd4, 8'h12);
        check("oam_wrap", 32'(oam_addr), 32'h00);
        cpu_rd(3'd4, 8'h5A);
        check("oam_noinc", 32'(oam_addr), 32'h00);

        // Reset in the middle of a video write cycle
        @(posedge clk); #1;
        cs_n = 1'b0; rw = 1'b0; rs = 3'd7; wdata = 8'h99;
        @(posedge clk); #1;
        cs_n = 1'b1; rw = 1'b1;
        check("midrst_we_active", 32'(v_we_n), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_we_n", 32'(v_we_n), 32'h1);
        check("midrst_ctrl", 32'(ctrl), 32'h0);
        check("midrst_int_n", 32'(int_n), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_v", 32'(v), 32'h0);
        check("midrst_port_idle", 32'(v_we_n), 32'h1);

        repeat (2) @(posedge clk);
        check("left_vwr", 32'(exp_vwr.size()), 32'h0);
        check("left_vrd", 32'(exp_vrd.size()), 32'h0);
        check("left_oam", 32'(exp_oam.size()), 32'h0);
        check("left_cpu", 32'(exp_cpu.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ppu_cpu_regs.md
Name: ppu_cpu_regs

Overview:
Next-generation PPU front end: the CPU-visible 8-register file of the 2C02 (PPUCTRL..PPUDATA) with loopy t/v scroll registers, write toggle, PPUDATA read buffer, vblank/NMI logic and a sequenced video-bus port. It sits between the CPU bus and the PPU rendering core. It replaces the PPU's stubbed-inactive ~NMI, ~RD and ~WE outputs with real drivers. It is parametrised in VRAM address width and OAM depth.

Parameters:
VADDR_W, 14, video bus address width; v/t are VADDR_W+1 bits, with the top 3 bits being fine-Y.
OAM_ADDR_W, 8, OAM address width; OAMADDR wraps at 2**OAM_ADDR_W.
INC_DOWN, 32, VRAM increment applied when PPUCTRL[2]=1 (otherwise 1).

Ports:
i_clk  in  1  clock.
i_reset_n  in  1  asynchronous active-low reset.
i_cs_n  in  1  register access strobe; low for exactly one cycle per CPU access.
i_rs  in  3  register select (0=CTRL 1=MASK 2=STATUS 3=OAMADDR 4=OAMDATA 5=SCROLL 6=ADDR 7=DATA).
i_rw  in  1  1=CPU read, 0=CPU write.
i_data  in  8  CPU write data.
o_data  out  8  CPU read data; combinational, valid while i_cs_n=0 and i_rw=1.
o_int_n  out  1  ~NMI to CPU.
i_vblank_set, i_vblank_clear  in  1  one-cycle pulses from the timing generator.
i_sprite0_hit, i_sprite_ovf  in  1  one-cycle set pulses; cleared by i_vblank_clear.
o_v_rd_n, o_v_we_n  out  1  video bus strobes.
o_v_address  out  VADDR_W  video address.
o_v_data  out  8  video write data.
i_v_data  in  8  video read data, sampled at the end of the o_v_rd_n-low cycle.
o_oam_addr  out  OAM_ADDR_W  OAM address.
o_oam_we  out  1  OAM write strobe.
o_oam_data  out  8  OAM write data.
i_oam_data  in  8  OAM read data.
o_ctrl, o_mask  out  8  register contents for the renderer.
o_v, o_t  out  VADDR_W+1  loopy registers.
o_fine_x  out  3  fine X scroll.

Behaviour:
- Reset: ctrl, mask, oamaddr, t, v, fine_x, w, buffer, and status flags all 0. o_int_n=1, o_v_rd_n=1, o_v_we_n=1, o_oam_we=0, o_data=0.
- All register side effects take place on the rising i_clk edge of the strobe cycle.
- CTRL write: ctrl<=d; t[11:10]<=d[1:0].
- MASK write: mask<=d.
- STATUS read: o_data={vbl,s0,ovf,5'b0}. Then vbl<=0 and w<=0.
- OAMADDR write: oamaddr<=d.
- OAMDATA write: o_oam_we=1 for the strobe cycle (combinational) with d; oamaddr increments and wraps.
- OAMDATA read: o_data=i_oam_data; no increment.
- SCROLL write, w=0: t[4:0]<=d[7:3], fine_x<=d[2:0].
- SCROLL write, w=1: t[14:12]<=d[2:0], t[9:5]<=d[7:3].
- Every SCROLL or ADDR write toggles w.
- ADDR write, w=0: t[13:8]<=d[5:0], t[14]<=0.
- ADDR write, w=1: t[7:0]<=d, v<=new t.
- DATA write: the next cycle drives o_v_we_n=0 for one cycle with o_v_address=v[VADDR_W-1:0] and o_v_data=d. v increments at the end of that cycle.
- DATA read: o_data=buffer (old value). The next cycle drives o_v_rd_n=0 for one cycle at v. At the end of that cycle, buffer<=i_v_data and v increments.
- Palette reads are buffered like any other address.
- Increment is 1 or INC_DOWN per ctrl[2]; v wraps modulo 2**(VADDR_W+1).
- Video port FSM: IDLE -> RD or WR (1 cycle) -> IDLE.
- A new strobe that arrives while in RD/WR is accepted for register effects. A second DATA access in that cycle is queued; depth 1 and it follows immediately. The CPU spacing guarantees no deeper backlog.
- Reads of write-only registers return the last value written to any register (open-bus latch), reset value 0.
- Flags: vbl is set by i_vblank_set and cleared by i_vblank_clear or a STATUS read. s0/ovf are set by their pulses and cleared by i_vblank_clear.
- Flag priority: set beats a same-cycle STATUS-read clear. The read still returns the pre-edge value.
- NMI: o_int_n = ~(vbl & ctrl[7]), registered. Writing ctrl[7]=1 while vbl=1 asserts o_int_n low on the next cycle.
- Reset mid-access: strobes are deasserted immediately (asynchronously) and the FSM returns to IDLE.

Decomposition:
- Shared package ppu_pkg holds:
  - register index constants REG_CTRL..REG_DATA;
  - status bit positions;
  - ctrl bit positions (NMI_EN=7, INC=2, NT=1:0);
  - the video-port state enum.
- Sub-module ppu_vram_port: the deferred read/write FSM with its 1-deep queue and v-increment request.

Test Plan:
- Reset -> o_int_n=1, o_v_rd_n=1, o_v_we_n=1, o_ctrl=0, o_v=0.
- Write ADDR 0x21 then 0x08 -> o_v=0x2108. Write DATA 0x55 -> next cycle o_v_we_n=0, o_v_address=0x2108, o_v_data=0x55; then o_v=0x2109. With ctrl[2]=1, the next write leaves o_v=0x2129.
- Memory holds 0xAA@0x2000 and 0xBB@0x2001; set ADDR 0x2000, then two DATA reads -> o_data returns 0x00, then 0xAA; buffer ends at 0xBB.
- CTRL=0x80, i_vblank_set pulse -> o_int_n=0 next cycle. STATUS read returns 0x80, then o_int_n=1 and a second read returns 0x00.
- SCROLL 0x7D then 0x5E: o_fine_x=5, o_t[4:0]=0x0F, o_t[9:5]=0x0B, o_t[14:12]=6. A STATUS read between the two writes resets w, so the 0x5E write becomes a first write instead.
- OAMADDR=0xFF, OAMDATA write 0x12 -> o_oam_we=1 at o_oam_addr 0xFF, then o_oam_addr=0x00 (wrap).
